// File: rtl/full_adder_pipe.sv
// Registered WIDTH-bit ripple-carry adder: {carry,sum} = a + b + cin, plus a signed-overflow flag.
// Define FULL_ADDER_PIPE_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module full_adder_pipe #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    // Operands as seen by the adder: either the ports or the optional input stage.
    logic             add_valid;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = add_cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = add_a[i] ^ add_b[i] ^ c[i];
            c[i+1] = (add_a[i] & add_b[i]) | (c[i] & (add_a[i] ^ add_b[i]));
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves it unassigned and no latch is inferred.
        out_valid_d = add_valid;
        sum_d       = sum_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        if (add_valid) begin
            sum_d   = s;
            carry_d = c[WIDTH];
            ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: state registers update with non-blocking assignments so all flops sample together.
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;

`ifdef FULL_ADDER_PIPE_IN_REG_EN
    logic             stg_valid_q, stg_valid_d;
    logic [WIDTH-1:0] stg_a_q, stg_a_d;
    logic [WIDTH-1:0] stg_b_q, stg_b_d;
    logic             stg_cin_q, stg_cin_d;

    // Valid shifts every cycle; operands are only taken when qualified.
    always_comb begin
        stg_valid_d = in_valid;
        stg_a_d     = stg_a_q;
        stg_b_d     = stg_b_q;
        stg_cin_d   = stg_cin_q;
        if (in_valid) begin
            stg_a_d   = a;
            stg_b_d   = b;
            stg_cin_d = cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= 1'b0;
            stg_a_q     <= '0;
            stg_b_q     <= '0;
            stg_cin_q   <= 1'b0;
        end else begin
            stg_valid_q <= stg_valid_d;
            stg_a_q     <= stg_a_d;
            stg_b_q     <= stg_b_d;
            stg_cin_q   <= stg_cin_d;
        end
    end

    assign add_valid = stg_valid_q;
    assign add_a     = stg_a_q;
    assign add_b     = stg_b_q;
    assign add_cin   = stg_cin_q;
`else
    assign add_valid = in_valid;
    assign add_a     = a;
    assign add_b     = b;
    assign add_cin   = cin;
`endif

endmodule

// File: tb/tb_full_adder_pipe.sv
// Directed bench for full_adder_pipe: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
// Expected results are hand-computed; a short delay line applies the build's latency.
module tb_full_adder_pipe;

`ifdef FULL_ADDER_PIPE_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic       v;
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       iv1, a1, b1, c1;
    logic       ov1, s1, co1, of1;
    logic       iv8, c8;
    logic [7:0] a8, b8;
    logic       ov8, co8, of8;
    logic [7:0] s8;

    int checks = 0;
    int errors = 0;

    exp_t q1[$];
    exp_t q8[$];
    exp_t pend1, pend8, hold1, hold8, e1, e8;

    full_adder_pipe #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .sum(s1), .carry(co1), .ovf(of1)
    );

    full_adder_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .sum(s8), .carry(co8), .ovf(of8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " w1 out_valid"}, 64'(ov1), 64'd0);
        check({tag, " w1 sum"},       64'(s1),  64'd0);
        check({tag, " w1 carry"},     64'(co1), 64'd0);
        check({tag, " w1 ovf"},       64'(of1), 64'd0);
        check({tag, " w8 out_valid"}, 64'(ov8), 64'd0);
        check({tag, " w8 sum"},       64'(s8),  64'd0);
        check({tag, " w8 carry"},     64'(co8), 64'd0);
        check({tag, " w8 ovf"},       64'(of8), 64'd0);
    endtask

    task automatic reset_model();
        q1.delete();
        q8.delete();
        for (int i = 0; i < LAT - 1; i++) begin
            q1.push_back('0);
            q8.push_back('0);
        end
        hold1 = '0;
        hold8 = '0;
        pend1 = '0;
        pend8 = '0;
        iv1   = 1'b0;
        iv8   = 1'b0;
    endtask

    task automatic drive1(input logic a, input logic b, input logic ci,
                          input logic es, input logic ec, input logic eo);
        iv1 = 1'b1; a1 = a; b1 = b; c1 = ci;
        pend1 = '{v: 1'b1, s: {7'd0, es}, c: ec, o: eo};
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec, input logic eo);
        iv8 = 1'b1; a8 = a; b8 = b; c8 = ci;
        pend8 = '{v: 1'b1, s: es, c: ec, o: eo};
    endtask

    // One clock: commit pending stimulus, sample #1 after the edge, then go idle with random operands.
    task automatic tick(input string tag);
        q1.push_back(pend1);
        q8.push_back(pend8);
        @(posedge clk);
        #1;
        e1 = q1.pop_front();
        e8 = q8.pop_front();
        if (e1.v) hold1 = e1;
        if (e8.v) hold8 = e8;
        check({tag, " w1 out_valid"}, 64'(ov1), 64'(e1.v));
        check({tag, " w1 sum"},       64'(s1),  64'(hold1.s[0]));
        check({tag, " w1 carry"},     64'(co1), 64'(hold1.c));
        check({tag, " w1 ovf"},       64'(of1), 64'(hold1.o));
        check({tag, " w8 out_valid"}, 64'(ov8), 64'(e8.v));
        check({tag, " w8 sum"},       64'(s8),  64'(hold8.s));
        check({tag, " w8 carry"},     64'(co8), 64'(hold8.c));
        check({tag, " w8 ovf"},       64'(of8), 64'(hold8.o));
        pend1 = '0;
        pend8 = '0;
        iv1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;
        reset_model();

        #12;
        check_zero("in reset");
        @(posedge clk);
        #1;
        check_zero("in reset after edge");
        rst_n = 1'b1;

        // Single-bit: 0+0+0, then 0+1+1 and 1+1+1 back to back.
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick("w1 000");
        drive1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick("w1 011");
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("w1 111");

        // Single-bit exhaustive sweep; ovf = carry ^ cin.
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick("sweep 000");
        drive1(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1); tick("sweep 001");
        drive1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick("sweep 010");
        drive1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick("sweep 011");
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick("sweep 100");
        drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick("sweep 101");
        drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick("sweep 110");
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0); tick("sweep 111");

        // 8-bit boundary and overflow vectors, issued back to back.
        drive8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0); tick("w8 ff+01");
        drive8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1); tick("w8 7f+01");
        drive8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0); tick("w8 ff+ff+1");
        drive8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0); tick("w8 zero");
        drive8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0); tick("w8 ff+00+1");
        drive8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1); tick("w8 80+80");

        // Hold: one result, then idle cycles with random operands.
        drive8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0); tick("w8 12+34");
        tick("hold 1");
        tick("hold 2");
        tick("hold 3");
        for (int i = 0; i < LAT; i++) tick("hold flush");

        // Fill the pipe so out_valid is high, then reset between edges.
        drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        tick("pre-reset 1");
        drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive8(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
        tick("pre-reset 2");
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async clear");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick("after release idle");
        drive8(8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);
        drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick("after release op");
        for (int i = 0; i < LAT; i++) tick("final flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
